// File: rtl/issue_controller_if.sv
// Decode-to-issue handshake bundle: one decoded instruction offered per cycle.
//   in_valid        decode offers an instruction
//   in_ready        issue controller accepts it this cycle
//   in_rs1/in_rs2   source register indices
//   in_use1/in_use2 source actually read by the instruction
//   in_rd, in_wr    destination index and write enable (rd==0 never writes)
//   in_unit         target functional unit (0 ALU, 1 MEM, 2 MUL, 3 DIV)
interface issue_controller_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned UNIT_W = 2;

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic              in_use1;
  logic              in_use2;
  logic [REG_W-1:0]  in_rd;
  logic              in_wr;
  logic [UNIT_W-1:0] in_unit;

  // Decode side drives the instruction, the controller answers with ready.
  modport master (
    output in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wr, in_unit,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wr, in_unit,
    output in_ready
  );
endinterface

// File: rtl/issue_controller.sv
// Issue-stage sequencer between decode and the register scoreboard.
// Holds one decoded instruction, blocks it on RAW hazards, write-back port
// collisions and a busy divider, then issues it and claims rd.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   dec (slave)                  decode handshake, see issue_controller_if
//   flush                        discard the held instruction
//   ass1_addr/ass2_addr          scoreboard lookup addresses (held rs1/rs2)
//   ass{1,2}_pending/unit/row    scoreboard lookup results
//   writeaddr, registerunit      rd and its unit for the scoreboard claim
//   enablewrite                  scoreboard claim strobe
//   issue, issue_unit            held instruction leaves to its unit
//   fwd1/fwd2                    {valid, unit} operand bypass selects
//   stall                        held instruction blocked this cycle
//   stall_cycles                 saturating count of stalled cycles
module issue_controller #(
  parameter int unsigned LAT_ALU  = 1,
  parameter int unsigned LAT_MEM  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 5,
  parameter int unsigned WB_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  issue_controller_if.slave    dec,
  input  logic                 flush,
  output logic [4:0]           ass1_addr,
  output logic [4:0]           ass2_addr,
  input  logic                 ass1_pending,
  input  logic                 ass2_pending,
  input  logic [1:0]           ass1_unit,
  input  logic [1:0]           ass2_unit,
  input  logic [4:0]           ass1_row,
  input  logic [4:0]           ass2_row,
  output logic [4:0]           writeaddr,
  output logic [1:0]           registerunit,
  output logic                 enablewrite,
  output logic                 issue,
  output logic [1:0]           issue_unit,
  output logic [2:0]           fwd1,
  output logic [2:0]           fwd2,
  output logic                 stall,
  output logic [15:0]          stall_cycles
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned UNIT_W = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SLOT_W = $clog2(WB_DEPTH);
  localparam int unsigned DIV_W  = $clog2(LAT_DIV + 1);

  // Scoreboard row one-hot 00001 means the producer sits in its final stage.
  localparam logic [REG_W-1:0] ROW_FINAL = 5'b00001;
  localparam logic [UNIT_W-1:0] UNIT_DIV = 2'd3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [REG_W-1:0]     h_rs1, h_rs2, h_rd;
  logic                 h_use1, h_use2, h_wr;
  logic [UNIT_W-1:0]    h_unit;
  logic [WB_DEPTH-1:0]  wb_slot, wb_shift, wb_next;
  logic [DIV_W-1:0]     div_cnt, div_cnt_next;
  logic [CNT_W-1:0]     stall_next;
  logic [SLOT_W-1:0]    slot_idx;
  logic                 div_busy, writes_rd, hold, haz1, haz2, struct_blk;
  logic                 ready, accept;

  // Hazard evaluation, issue decision and combinational outputs.
  always_comb begin
    slot_idx = SLOT_W'(LAT_ALU - 1);
    case (h_unit)
      2'd0: slot_idx = SLOT_W'(LAT_ALU - 1);
      2'd1: slot_idx = SLOT_W'(LAT_MEM - 1);
      2'd2: slot_idx = SLOT_W'(LAT_MUL - 1);
      2'd3: slot_idx = SLOT_W'(LAT_DIV - 1);
      default: slot_idx = SLOT_W'(LAT_ALU - 1);
    endcase

    // The reservation vector is checked after this cycle's shift, so bit
    // LAT-1 of the shifted view is the slot an issue now would land in.
    wb_shift   = wb_slot >> 1;
    div_busy   = (div_cnt != '0);
    writes_rd  = h_wr & (h_rd != '0);
    hold       = (state_q == S_HELD) & ~flush;

    haz1       = h_use1 & ass1_pending & (ass1_row != ROW_FINAL);
    haz2       = h_use2 & ass2_pending & (ass2_row != ROW_FINAL);
    struct_blk = (writes_rd & wb_shift[slot_idx]) | ((h_unit == UNIT_DIV) & div_busy);

    issue       = hold & ~haz1 & ~haz2 & ~struct_blk;
    stall       = hold & ~issue;
    enablewrite = issue & writes_rd;
    ready       = ((state_q == S_EMPTY) | issue) & ~flush;
    accept      = dec.in_valid & ready;

    fwd1 = '0;
    fwd2 = '0;
    if ((state_q == S_HELD) & h_use1 & ass1_pending & (ass1_row == ROW_FINAL))
      fwd1 = {1'b1, ass1_unit};
    if ((state_q == S_HELD) & h_use2 & ass2_pending & (ass2_row == ROW_FINAL))
      fwd2 = {1'b1, ass2_unit};

    dec.in_ready = ready;
    ass1_addr    = h_rs1;
    ass2_addr    = h_rs2;
    writeaddr    = h_rd;
    registerunit = h_unit;
    issue_unit   = h_unit;
  end

  // Next-state and resource bookkeeping.
  always_comb begin
    state_d      = state_q;
    wb_next      = wb_shift;
    div_cnt_next = div_cnt;
    stall_next   = stall_cycles;

    case (state_q)
      S_EMPTY: if (accept) state_d = S_HELD;
      S_HELD: begin
        if (flush)      state_d = S_EMPTY;
        else if (issue) state_d = accept ? S_HELD : S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase

    if (enablewrite)
      wb_next = wb_shift | (WB_DEPTH'(1) << slot_idx);

    if (issue & (h_unit == UNIT_DIV))
      div_cnt_next = DIV_W'(LAT_DIV - 1);
    else if (div_busy)
      div_cnt_next = div_cnt - DIV_W'(1);

    if (stall & (stall_cycles != '1))
      stall_next = stall_cycles + CNT_W'(1);
  end

  // State, held instruction and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      wb_slot      <= '0;
      div_cnt      <= '0;
      stall_cycles <= '0;
      h_rs1        <= '0;
      h_rs2        <= '0;
      h_rd         <= '0;
      h_use1       <= 1'b0;
      h_use2       <= 1'b0;
      h_wr         <= 1'b0;
      h_unit       <= '0;
    end else begin
      state_q      <= state_d;
      wb_slot      <= wb_next;
      div_cnt      <= div_cnt_next;
      stall_cycles <= stall_next;
      if (accept) begin
        h_rs1  <= dec.in_rs1;
        h_rs2  <= dec.in_rs2;
        h_rd   <= dec.in_rd;
        h_use1 <= dec.in_use1;
        h_use2 <= dec.in_use2;
        h_wr   <= dec.in_wr;
        h_unit <= dec.in_unit;
      end
    end
  end

endmodule
